// File: rtl/ms_width_stage.sv
// ============================================================================
// Module   : ms_width_stage
// Brief    : Mid/side stereo-width stage. Scales side by a Q2.14 gain over a
//            2-stage valid/ready pipeline. Optional macro MS_WIDTH_RAMP_EN
//            enables a stepped gain ramp FSM instead of immediate gain loads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_width_stage #(
  parameter logic [15:0] RAMP_STEP = 16'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] mid_in,
  input  logic [15:0] side_in,
  input  logic [15:0] gain_tgt,
  input  logic        gain_load,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] mid_out,
  output logic [15:0] side_out,
  output logic        ramp_busy
);

  localparam logic [15:0] C_UNITY = 16'h4000;

  logic               w_advance;
  logic               w_accept;
  logic               r_v1;
  logic [15:0]        r_mid1;
  logic signed [31:0] r_prod1;
  logic [15:0]        r_gain;
  logic signed [32:0] w_side_x;
  logic signed [32:0] w_gain_x;
  logic signed [32:0] w_prod;
  logic signed [32:0] w_rnd;
  logic signed [18:0] w_shifted;
  logic [15:0]        w_sat;

  assign w_advance = ce & (~out_valid | out_ready);
  assign w_accept  = in_valid & w_advance;
  assign in_ready  = w_advance;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign w_side_x = {{17{side_in[15]}}, side_in};
  assign w_gain_x = {17'd0, r_gain};
  assign w_prod   = w_side_x * w_gain_x;

  assign w_rnd     = {r_prod1[31], r_prod1} + 33'sd8192;
  assign w_shifted = w_rnd[32:14];

  always_comb begin
    w_sat = w_shifted[15:0];
    if (w_shifted > 19'sd32767) begin
      w_sat = 16'h7FFF;
    end else if (w_shifted < -19'sd32768) begin
      w_sat = 16'h8000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_mid1    <= 16'd0;
      r_prod1   <= 32'sd0;
      out_valid <= 1'b0;
      mid_out   <= 16'd0;
      side_out  <= 16'd0;
    end else if (w_advance) begin
      r_v1      <= in_valid;
      out_valid <= r_v1;
      if (in_valid) begin
        r_mid1  <= mid_in;
        r_prod1 <= w_prod[31:0];
      end
      if (r_v1) begin
        mid_out  <= r_mid1;
        side_out <= w_sat;
      end
    end
  end

`ifdef MS_WIDTH_RAMP_EN
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RAMP = 1'b1} state_t;

  state_t             r_state;
  logic [15:0]        r_tgt;
  logic signed [17:0] w_diff;
  logic signed [17:0] w_step;

  assign w_diff    = $signed({2'b00, r_tgt}) - $signed({2'b00, r_gain});
  assign w_step    = $signed({2'b00, RAMP_STEP});
  assign ramp_busy = (r_state == S_RAMP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gain  <= C_UNITY;
      r_tgt   <= C_UNITY;
    end else if (ce) begin
      if (w_accept && r_state == S_RAMP) begin
        if (w_diff > w_step) begin
          r_gain <= r_gain + RAMP_STEP;
        end else if (w_diff < -w_step) begin
          r_gain <= r_gain - RAMP_STEP;
        end else begin
          r_gain  <= r_tgt;
          r_state <= S_IDLE;
        end
      end
      // A coincident load wins the state, but the step above used the old target.
      if (gain_load) begin
        r_tgt   <= gain_tgt;
        r_state <= S_RAMP;
      end
    end
  end
`else
  assign ramp_busy = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gain <= C_UNITY;
    end else if (ce && gain_load) begin
      r_gain <= gain_tgt;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ms_width_stage.sv
// ============================================================================
// Module   : tb_ms_width_stage
// Brief    : Self-checking bench for ms_width_stage (vectors, corner
//            sequences and random traffic against a behavioural model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ms_width_stage;

  localparam int STEP = 64;

  logic        clk = 1'b0;
  logic        rst, ce, in_valid, in_ready, gain_load, out_valid, out_ready, ramp_busy;
  logic [15:0] mid_in, side_in, gain_tgt, mid_out, side_out;

  always #5 clk = ~clk;

  ms_width_stage #(.RAMP_STEP(16'd64)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .mid_in(mid_in), .side_in(side_in), .gain_tgt(gain_tgt), .gain_load(gain_load),
    .out_valid(out_valid), .out_ready(out_ready), .mid_out(mid_out),
    .side_out(side_out), .ramp_busy(ramp_busy)
  );

  // Reference model: gain state plus a two-slot delay line of finished results.
  int m_gain, m_tgt, m_mid, m_side, s1m, s1s;
  bit m_busy, m_ov, s1v, m_acc;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    int gain; int mid; int side; int emid; int eside;
  } vec_t;
  vec_t vt[8];

  function automatic int exp_side(int s, int g);
    longint p;
    p = (longint'(s) * longint'(g) + 64'sd8192) >>> 14;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return int'(p);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    bit adv;
    @(negedge clk);
    check("in_ready", int'(in_ready), int'(ce && (!m_ov || out_ready)));
    @(posedge clk);
    m_acc = 1'b0;
    if (rst) begin
      m_gain = 16'h4000; m_tgt = 16'h4000; m_busy = 1'b0;
      m_ov = 1'b0; s1v = 1'b0; m_mid = 0; m_side = 0;
    end else if (ce) begin
      adv = !m_ov || out_ready;
      if (adv) begin
        m_acc = in_valid;
        m_ov  = s1v;
        if (s1v) begin m_mid = s1m; m_side = s1s; end
        s1v = in_valid;
        if (in_valid) begin
          s1m = int'($signed(mid_in));
          s1s = exp_side(int'($signed(side_in)), m_gain);
        end
      end
`ifdef MS_WIDTH_RAMP_EN
      if (m_acc && m_busy) begin
        if (m_tgt > m_gain + STEP) m_gain += STEP;
        else if (m_tgt < m_gain - STEP) m_gain -= STEP;
        else begin m_gain = m_tgt; m_busy = 1'b0; end
      end
      if (gain_load) begin m_tgt = int'(gain_tgt); m_busy = 1'b1; end
`else
      if (gain_load) m_gain = int'(gain_tgt);
`endif
    end
    #1;
    check("out_valid", int'(out_valid), int'(m_ov));
    check("mid_out", int'($signed(mid_out)), m_mid);
    check("side_out", int'($signed(side_out)), m_side);
    check("ramp_busy", int'(ramp_busy), int'(m_busy));
  endtask

  task automatic send(input int m, input int s);
    in_valid = 1'b1; mid_in = 16'(m); side_in = 16'(s);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (m_acc) break;
    end
    check("send_accepted", int'(m_acc), 1);
    in_valid = 1'b0;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic settle_gain(input int g);
    gain_tgt = 16'(g); gain_load = 1'b1;
    tick();
    gain_load = 1'b0;
`ifdef MS_WIDTH_RAMP_EN
    in_valid = 1'b1; mid_in = 16'd0; side_in = 16'd0;
    for (int i = 0; i < 2000 && m_busy; i++) tick();
    in_valid = 1'b0;
    check("settle_busy", int'(ramp_busy), 0);
`endif
    flush(3);
  endtask

  initial begin
    int cnt;
    vt[0] = '{16'h4000, 1000, -2000, 1000, -2000};
    vt[1] = '{16'h8000, -5, 20000, -5, 32767};
    vt[2] = '{16'h8000, 77, -20000, 77, -32768};
    vt[3] = '{16'h2000, 1, 3, 1, 2};
    vt[4] = '{16'h2000, 2, -3, 2, -1};
    vt[5] = '{16'h4000, -32768, -32768, -32768, -32768};
    vt[6] = '{16'hC000, 32767, 100, 32767, 300};
    vt[7] = '{16'h0000, 9, 1234, 9, 0};

    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; gain_load = 1'b0;
    mid_in = '0; side_in = '0; gain_tgt = 16'h4000;
    m_gain = 16'h4000; m_tgt = 16'h4000; m_busy = 0; m_ov = 0; s1v = 0;
    m_mid = 0; m_side = 0; s1m = 0; s1s = 0; m_acc = 0;
    flush(2);
    rst = 1'b0;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_side_out", int'(side_out), 0);

    // Unity path straight after reset: two advancing cycles of latency.
    send(1000, -2000);
    tick();
    check("unity_mid", int'($signed(mid_out)), 1000);
    check("unity_side", int'($signed(side_out)), -2000);
    flush(2);

    foreach (vt[k]) begin
      settle_gain(vt[k].gain);
      send(vt[k].mid, vt[k].side);
      flush(4);
      check("vec_mid", int'($signed(mid_out)), vt[k].emid);
      check("vec_side", int'($signed(side_out)), vt[k].eside);
    end
    settle_gain(16'h4000);

    // Backpressure with a full pipeline, then release and drain.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid_in = 16'(100 + i); side_in = 16'(-50 * i); tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid_in = 16'(200 + i); tick();
      check("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    flush(4);
    ce = 1'b0; in_valid = 1'b1; flush(3); ce = 1'b1; in_valid = 1'b0;
    flush(3);

    // Ramp 1.0 -> 0.0 with a constant side level.
    rst = 1'b1; tick(); rst = 1'b0;
    gain_tgt = 16'h0000; gain_load = 1'b1; tick(); gain_load = 1'b0;
    in_valid = 1'b1; side_in = 16'd16384; mid_in = 16'd0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (m_acc) cnt++;
      if (!ramp_busy) break;
    end
`ifdef MS_WIDTH_RAMP_EN
    check("ramp_accepts", cnt, 256);
`else
    check("ramp_accepts", cnt, 1);
`endif
    in_valid = 1'b0; flush(3);
    send(0, 16384); flush(3);
    check("ramp_final", int'($signed(side_out)), 0);

    // Reset in the middle of a ramp.
    settle_gain(16'h4000);
    gain_tgt = 16'h0000; gain_load = 1'b1; tick(); gain_load = 1'b0;
    in_valid = 1'b1; side_in = 16'd1000; flush(20);
    rst = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_ramp_busy", int'(ramp_busy), 0);
    send(7, -2000); flush(3);
    check("rst_unity_side", int'($signed(side_out)), -2000);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      ce        = ($urandom_range(9) != 0);
      in_valid  = $urandom_range(1);
      out_ready = ($urandom_range(3) != 0);
      mid_in    = 16'($urandom);
      side_in   = 16'($urandom);
      gain_load = ($urandom_range(49) == 0);
      gain_tgt  = 16'($urandom);
      tick();
    end
    ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; gain_load = 1'b0;
    flush(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
